// File: rtl/serial_reg_master_if.sv
// Request/response handshake between the control-side requester and serial_reg_master.
// Serial pins to the regfile stay plain ports on the master itself.
`timescale 1ns/1ps
interface serial_reg_master_if;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic       REQ_WRITE;
   logic [7:0] REQ_ADDR;
   logic [7:0] REQ_WDATA;
   logic       RSP_VALID;
   logic [7:0] RSP_RDATA;
   logic       WR_ERR;

   modport master (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input  REQ_READY, RSP_VALID, RSP_RDATA, WR_ERR
   );

   modport slave (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      output REQ_READY, RSP_VALID, RSP_RDATA, WR_ERR
   );
endinterface

// File: rtl/serial_reg_master.sv
// Parallel-request to serial-frame bridge for the serial register file (strobe, 8 addr, 8 data, MSB first).
// Define SRM_WR_VERIFY_EN to read back every write and flag mismatches on WR_ERR.
//
// state     | meaning
// IDLE      | REQ_READY high, waiting for a request
// STRB      | one-cycle WR_EN or RD_EN strobe
// ADDR      | shifting out address bits 7..0
// DATA      | shifting out write data, or capturing read data from SER_DIN
// RESP      | RSP_VALID pulse, back to IDLE next cycle
// VRFY_STRB | read strobe of the readback frame (verify build only)
// VRFY_ADDR | readback address bits 7..0 (verify build only)
// VRFY_DATA | capturing readback data (verify build only)
`timescale 1ns/1ps
module serial_reg_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RSTN,
   serial_reg_master_if.slave bus,
   output logic               WR_EN,
   output logic               RD_EN,
   output logic               SER_DOUT,
   input  logic               SER_DIN
);

   typedef enum logic [2:0] {
      IDLE,
      STRB,
      ADDR,
      DATA,
      RESP
`ifdef SRM_WR_VERIFY_EN
      , VRFY_STRB,
      VRFY_ADDR,
      VRFY_DATA
`endif
   } state_t;

   state_t                  state_q;
   logic [2:0]              cnt_q;
   logic                    wr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   cap_q;
   logic                    ready_q;
   logic                    wr_en_q;
   logic                    rd_en_q;
   logic                    dout_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
`ifdef SRM_WR_VERIFY_EN
   logic                    wr_err_q;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cap_q       <= '0;
         ready_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         dout_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef SRM_WR_VERIFY_EN
         wr_err_q    <= 1'b0;
`endif
      end else begin
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus.REQ_VALID && ready_q) begin
                  ready_q <= 1'b0;
                  wr_q    <= bus.REQ_WRITE;
                  addr_q  <= bus.REQ_ADDR;
                  wdata_q <= bus.REQ_WDATA;
                  wr_en_q <= bus.REQ_WRITE;
                  rd_en_q <= ~bus.REQ_WRITE;
                  state_q <= STRB;
               end
            end
            STRB: begin
               dout_q  <= addr_q[ADDR_WIDTH-1];
               cnt_q   <= 3'd7;
               state_q <= ADDR;
            end
            ADDR: begin
               if (cnt_q == 3'd0) begin
                  dout_q  <= wr_q & wdata_q[DATA_WIDTH-1];
                  cnt_q   <= 3'd7;
                  state_q <= DATA;
               end else begin
                  dout_q <= addr_q[cnt_q - 3'd1];
                  cnt_q  <= cnt_q - 3'd1;
               end
            end
            DATA: begin
               cap_q <= {cap_q[DATA_WIDTH-2:0], SER_DIN};
               if (cnt_q == 3'd0) begin
                  dout_q <= 1'b0;
`ifdef SRM_WR_VERIFY_EN
                  // Writes chain straight into a readback frame of the same address.
                  if (wr_q) begin
                     rd_en_q <= 1'b1;
                     state_q <= VRFY_STRB;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= {cap_q[DATA_WIDTH-2:0], SER_DIN};
                     wr_err_q    <= 1'b0;
                     state_q     <= RESP;
                  end
`else
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= wr_q ? {DATA_WIDTH{1'b0}} : {cap_q[DATA_WIDTH-2:0], SER_DIN};
                  state_q     <= RESP;
`endif
               end else begin
                  dout_q <= wr_q & wdata_q[cnt_q - 3'd1];
                  cnt_q  <= cnt_q - 3'd1;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
`ifdef SRM_WR_VERIFY_EN
            VRFY_STRB: begin
               dout_q  <= addr_q[ADDR_WIDTH-1];
               cnt_q   <= 3'd7;
               state_q <= VRFY_ADDR;
            end
            VRFY_ADDR: begin
               if (cnt_q == 3'd0) begin
                  dout_q  <= 1'b0;
                  cnt_q   <= 3'd7;
                  state_q <= VRFY_DATA;
               end else begin
                  dout_q <= addr_q[cnt_q - 3'd1];
                  cnt_q  <= cnt_q - 3'd1;
               end
            end
            VRFY_DATA: begin
               cap_q <= {cap_q[DATA_WIDTH-2:0], SER_DIN};
               if (cnt_q == 3'd0) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= {cap_q[DATA_WIDTH-2:0], SER_DIN};
                  wr_err_q    <= ({cap_q[DATA_WIDTH-2:0], SER_DIN} != wdata_q);
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
`endif
            default: begin
               ready_q <= 1'b0;
               dout_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.REQ_READY = ready_q;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_RDATA = rsp_rdata_q;
`ifdef SRM_WR_VERIFY_EN
   assign bus.WR_ERR    = wr_err_q;
`else
   assign bus.WR_ERR    = 1'b0;
`endif
   assign WR_EN    = wr_en_q;
   assign RD_EN    = rd_en_q;
   assign SER_DOUT = dout_q;

endmodule

// File: tb/tb_serial_reg_master.sv
// Bench for serial_reg_master with a behavioural serial regfile as the slave.
// Builds with or without SRM_WR_VERIFY_EN; the verify scenarios only run when it is defined.
`timescale 1ns/1ps
module tb_serial_reg_master;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   logic WR_EN, RD_EN, SER_DOUT, SER_DIN;

   serial_reg_master_if bus();

   serial_reg_master dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .bus      (bus),
      .WR_EN    (WR_EN),
      .RD_EN    (RD_EN),
      .SER_DOUT (SER_DOUT),
      .SER_DIN  (SER_DIN)
   );

   always #5 CLK = ~CLK;

`ifdef SRM_WR_VERIFY_EN
   localparam bit VERIFY_ON = 1'b1;
`else
   localparam bit VERIFY_ON = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural regfile slave ----------------
   logic [7:0] r34, r78, ra1, r06;
   logic [4:0] s_cnt;
   logic       s_wr;
   logic [7:0] s_addr, s_data, s_rsh, s_rd;

   function automatic logic [7:0] reg_rd(input logic [7:0] a);
      case (a)
         8'h34:   return r34;
         8'h78:   return r78;
         8'hA1:   return ra1;
         8'h06:   return r06;
         8'h55:   return 8'h33;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s_cnt <= 5'd0; s_wr <= 1'b0; s_addr <= 8'h00; s_data <= 8'h00; s_rsh <= 8'h00;
         SER_DIN <= 1'b0;
         r34 <= 8'h00; r78 <= 8'h00; ra1 <= 8'h00; r06 <= 8'h00;
      end else if (WR_EN || RD_EN) begin
         s_cnt <= 5'd1; s_wr <= WR_EN; SER_DIN <= 1'b0;
      end else if (s_cnt != 5'd0) begin
         s_cnt <= (s_cnt == 5'd16) ? 5'd0 : s_cnt + 5'd1;
         if (s_cnt <= 5'd8) s_addr <= {s_addr[6:0], SER_DOUT};
         else               s_data <= {s_data[6:0], SER_DOUT};
         if (s_cnt == 5'd8 && !s_wr) begin
            s_rd = reg_rd({s_addr[6:0], SER_DOUT});
            SER_DIN <= s_rd[7];
            s_rsh   <= {s_rd[6:0], 1'b0};
         end else if (s_cnt >= 5'd9 && s_cnt <= 5'd15 && !s_wr) begin
            SER_DIN <= s_rsh[7];
            s_rsh   <= {s_rsh[6:0], 1'b0};
         end else begin
            SER_DIN <= 1'b0;
         end
         if (s_cnt == 5'd16 && s_wr) begin
            case (s_addr)
               8'h34: r34 <= {s_data[6:0], SER_DOUT};
               8'h78: r78 <= {s_data[6:0], SER_DOUT};
               8'hA1: ra1 <= {s_data[6:0], SER_DOUT};
               8'h06: r06 <= {s_data[6:0], SER_DOUT};
               default: ;
            endcase
         end
      end
   end

   // ---------------- scoreboard and frame monitor ----------------
   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       e;
   int         cyc = 0;
   int         k   = 0;
   int         lat = 18;
   int         acc_prev = 0, acc_last = 0;
   logic       busy = 1'b0;
   logic       rdy_chk = 1'b0;
   logic       cur_wr;
   logic [7:0] cur_a, cur_d;
   logic [7:0] hold_exp = 8'h00;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (!RSTN) begin
         busy = 1'b0; k = 0; rdy_chk = 1'b0; hold_exp = 8'h00;
      end else begin
         chk("strb_excl", WR_EN & RD_EN, 0);
         if (rdy_chk) begin
            chk("ready_after_rsp", bus.REQ_READY, 1);
            rdy_chk = 1'b0;
         end
         if (busy) begin
            k++;
            chk("ready_busy", bus.REQ_READY, 0);
            if (k == 1) begin
               chk("wr_en_strb", WR_EN, cur_wr);
               chk("rd_en_strb", RD_EN, !cur_wr);
            end else if (k <= 17) begin
               chk("wr_en_off", WR_EN, 0);
               chk("rd_en_off", RD_EN, 0);
            end
            if (k >= 2 && k <= 9)        chk("dout_addr", SER_DOUT, cur_a[9-k]);
            else if (k >= 10 && k <= 17) chk("dout_data", SER_DOUT, cur_wr ? cur_d[17-k] : 1'b0);
`ifdef SRM_WR_VERIFY_EN
            if (cur_wr && k == 18)              chk("vrfy_strb", RD_EN, 1);
            if (cur_wr && k >= 19 && k <= 26)   chk("vrfy_addr", SER_DOUT, cur_a[26-k]);
`endif
            if (k < lat) begin
               chk("rsp_early", bus.RSP_VALID, 0);
               chk("rdata_hold", bus.RSP_RDATA, hold_exp);
            end else begin
               chk("rsp_valid", bus.RSP_VALID, 1);
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", bus.RSP_RDATA, e.rdata);
                  chk("rsp_wr_err", bus.WR_ERR, e.err);
                  hold_exp = e.rdata;
               end
               busy = 1'b0;
               rdy_chk = 1'b1;
            end
         end else begin
            chk("idle_rsp", bus.RSP_VALID, 0);
            chk("idle_strb", WR_EN | RD_EN, 0);
            chk("idle_dout", SER_DOUT, 0);
            chk("rdata_hold", bus.RSP_RDATA, hold_exp);
         end
         if (!busy && !rdy_chk && bus.REQ_VALID && bus.REQ_READY) begin
            busy = 1'b1; k = 0;
            cur_wr = bus.REQ_WRITE; cur_a = bus.REQ_ADDR; cur_d = bus.REQ_WDATA;
            if (exp_q.size() == 0) begin
               chk("acc_unexpected", 1, 0);
               lat = 18;
            end else begin
               lat = exp_q[0].lat;
            end
            acc_prev = acc_last;
            acc_last = cyc;
         end else if (bus.REQ_VALID && bus.REQ_READY) begin
            // handshake in the cycle right after a response: still consumed normally
            busy = 1'b1; k = 0;
            cur_wr = bus.REQ_WRITE; cur_a = bus.REQ_ADDR; cur_d = bus.REQ_WDATA;
            lat = (exp_q.size() == 0) ? 18 : exp_q[0].lat;
            if (exp_q.size() == 0) chk("acc_unexpected", 1, 0);
            acc_prev = acc_last;
            acc_last = cyc;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic int wr_lat();
      return VERIFY_ON ? 35 : 18;
   endfunction

   function automatic exp_t wr_exp(input logic [7:0] d, input logic [7:0] readback);
      exp_t x;
      x.rdata = VERIFY_ON ? readback : 8'h00;
      x.err   = VERIFY_ON && (readback != d);
      x.lat   = wr_lat();
      return x;
   endfunction

   function automatic exp_t rd_exp(input logic [7:0] rdata);
      exp_t x;
      x.rdata = rdata;
      x.err   = 1'b0;
      x.lat   = 18;
      return x;
   endfunction

   task automatic present(input logic w, input logic [7:0] a, input logic [7:0] d);
      logic got;
      got = 1'b0;
      bus.REQ_VALID = 1'b1; bus.REQ_WRITE = w; bus.REQ_ADDR = a; bus.REQ_WDATA = d;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge CLK);
         if (bus.REQ_READY) begin
            @(posedge CLK);
            #1;
            got = 1'b1;
         end
      end
      if (!got) chk("accept_timeout", 1, 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         @(posedge CLK);
         n++;
      end
      if (n >= 200) begin
         chk("done_timeout", 1, 0);
         exp_q.delete();
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] readback);
      exp_q.push_back(wr_exp(d, readback));
      present(1'b1, a, d);
      bus.REQ_VALID = 1'b0;
      wait_done();
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] rdata);
      exp_q.push_back(rd_exp(rdata));
      present(1'b0, a, 8'h00);
      bus.REQ_VALID = 1'b0;
      wait_done();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ready"},  bus.REQ_READY, 0);
      chk({tag, "_rspv"},   bus.RSP_VALID, 0);
      chk({tag, "_rdata"},  bus.RSP_RDATA, 0);
      chk({tag, "_wr_err"}, bus.WR_ERR, 0);
      chk({tag, "_wr_en"},  WR_EN, 0);
      chk({tag, "_rd_en"},  RD_EN, 0);
      chk({tag, "_dout"},   SER_DOUT, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.REQ_VALID = 1'b0; bus.REQ_WRITE = 1'b0; bus.REQ_ADDR = 8'h00; bus.REQ_WDATA = 8'h00;
      RSTN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_outputs_zero("reset");
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      chk("ready_before_edge", bus.REQ_READY, 0);
      @(posedge CLK);
      #1;
      chk("ready_after_release", bus.REQ_READY, 1);

      // write frame with serial pattern, then reads and read-after-write
      do_write(8'h78, 8'hC5, 8'hC5);
      do_read (8'h55, 8'h33);
      do_write(8'h34, 8'hAA, 8'hAA);
      do_read (8'h34, 8'hAA);
      do_read (8'h78, 8'hC5);

      // back-to-back requests with REQ_VALID held
      exp_q.push_back(wr_exp(8'h3C, 8'h3C));
      exp_q.push_back(rd_exp(8'h3C));
      present(1'b1, 8'hA1, 8'h3C);
      present(1'b0, 8'hA1, 8'h00);
      bus.REQ_VALID = 1'b0;
      chk("b2b_gap", acc_last - acc_prev, wr_lat() + 1);
      wait_done();

      // reset during S+5 of a write frame
      exp_q.push_back(wr_exp(8'h99, 8'h99));
      present(1'b1, 8'h78, 8'h99);
      bus.REQ_VALID = 1'b0;
      repeat (5) @(posedge CLK);
      #3;
      RSTN = 1'b0;
      #1;
      chk_outputs_zero("abort");
      exp_q.delete();
      repeat (3) @(posedge CLK);
      #1;
      chk("abort_no_rsp", bus.RSP_VALID, 0);
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      chk("abort_ready_pre", bus.REQ_READY, 0);
      @(posedge CLK);
      #1;
      chk("abort_ready_post", bus.REQ_READY, 1);
      do_read(8'h78, 8'h00);

      // unmapped and read-only addresses
      do_read (8'h00, 8'h00);
      do_write(8'h06, 8'h5A, 8'h5A);
      do_read (8'h06, 8'h5A);
`ifdef SRM_WR_VERIFY_EN
      do_write(8'h55, 8'h12, 8'h33);
      do_write(8'h06, 8'hA5, 8'hA5);
`else
      do_write(8'h55, 8'h12, 8'h33);
`endif
      do_read (8'h55, 8'h33);

      repeat (3) @(posedge CLK);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
